// File: rtl/hazard_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_seq
// Brief   : EX>MEM>WB operand forwarding, load-use stall FSM, memory freeze
//           and saturating stall/forward performance counters.
// Revision: 1.0
// ============================================================================
module hazard_ctrl_seq #(
  parameter int DATA_W   = 16,
  parameter int RADDR_W  = 4,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_busy,
  input  logic               flush,
  input  logic               perf_clr,
  input  logic [RADDR_W-1:0] fd_rs,
  input  logic [RADDR_W-1:0] fd_rt,
  input  logic               fd_rs_used,
  input  logic               fd_rt_used,
  input  logic [RADDR_W-1:0] dx_rd,
  input  logic [RADDR_W-1:0] xm_rd,
  input  logic [RADDR_W-1:0] mw_rd,
  input  logic               dx_wr,
  input  logic               xm_wr,
  input  logic               mw_wr,
  input  logic               dx_ld,
  input  logic               xm_ld,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic [DATA_W-1:0]  mem_result,
  input  logic [DATA_W-1:0]  wb_result,
  output logic [DATA_W-1:0]  corr_rs,
  output logic [DATA_W-1:0]  corr_rt,
  output logic               fwd_rs,
  output logic               fwd_rt,
  output logic               stl,
  output logic               freeze,
  output logic               busy,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   fwd_cnt
);

  localparam bit MEM_LD_OK = (LOAD_LAT == 1);
  localparam bit LAT2      = (LOAD_LAT == 2);
  localparam int LAT_W     = 2;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [LAT_W-1:0]         lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]         fwd_cnt_q, fwd_cnt_d;

  logic [1:0][RADDR_W-1:0]  src;
  logic [1:0]               live;
  logic [1:0]               hit;
  logic [1:0]               ld_hz;
  logic [1:0][DATA_W-1:0]   val;
  logic                     lu_hz;
  logic                     stl_raw;

  assign src  = {fd_rt, fd_rs};
  assign live = {fd_rt_used && (fd_rt != '0), fd_rs_used && (fd_rs != '0)};

  // The youngest matching stage decides; a matching load that cannot forward
  // yet hides older stages so stale data is never selected.
  always_comb begin
    hit   = '0;
    val   = '0;
    ld_hz = '0;
    for (int i = 0; i < 2; i++) begin
      if (live[i]) begin
        if (dx_wr && (dx_rd == src[i])) begin
          if (!dx_ld) begin
            hit[i] = 1'b1;
            val[i] = ex_result;
          end
        end else if (xm_wr && (xm_rd == src[i])) begin
          if (!xm_ld || MEM_LD_OK) begin
            hit[i] = 1'b1;
            val[i] = mem_result;
          end
        end else if (mw_wr && (mw_rd == src[i])) begin
          hit[i] = 1'b1;
          val[i] = wb_result;
        end
        ld_hz[i] = (dx_ld && dx_wr && (dx_rd == src[i])) ||
                   (LAT2 && xm_ld && xm_wr && (xm_rd == src[i]));
      end
    end
  end

  assign lu_hz = |ld_hz;

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    stl_raw   = 1'b0;
    case (state_q)
      RUN: begin
        // Flush squashes the dependent instruction; ignored while frozen.
        stl_raw = lu_hz && (mem_busy || !flush);
        if (!mem_busy && lu_hz && !flush && LAT2) begin
          state_d   = LU_STALL;
          lat_cnt_d = LAT_W'(LOAD_LAT - 1);
        end
      end
      LU_STALL: begin
        stl_raw = 1'b1;
        if (!mem_busy) begin
          if (flush) begin
            state_d   = RUN;
            lat_cnt_d = '0;
          end else if (lat_cnt_q == LAT_W'(1)) begin
            state_d   = RUN;
            lat_cnt_d = '0;
          end else begin
            lat_cnt_d = lat_cnt_q - LAT_W'(1);
          end
        end
      end
      default: begin
        state_d   = RUN;
        lat_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (!mem_busy) begin
      if (perf_clr) begin
        stall_cnt_d = '0;
        fwd_cnt_d   = '0;
      end else begin
        if (stl_raw && !(&stall_cnt_q)) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!stl_raw && (|hit) && !(&fwd_cnt_q)) begin
          fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      lat_cnt_q   <= '0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign corr_rs   = rst_n ? val[0] : '0;
  assign corr_rt   = rst_n ? val[1] : '0;
  assign fwd_rs    = rst_n && hit[0];
  assign fwd_rt    = rst_n && hit[1];
  assign stl       = rst_n && stl_raw;
  assign freeze    = rst_n && mem_busy;
  assign busy      = (state_q == LU_STALL);
  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl_seq
// Brief   : Directed self-checking bench; u_lat1 uses LOAD_LAT=1, u_lat2 uses
//           LOAD_LAT=2 with 4-bit counters so saturation is reachable.
// Revision: 1.0
// ============================================================================
module tb_hazard_ctrl_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mem_busy, flush, perf_clr;
  logic [3:0]  fd_rs, fd_rt, dx_rd, xm_rd, mw_rd;
  logic        fd_rs_used, fd_rt_used, dx_wr, xm_wr, mw_wr, dx_ld, xm_ld;
  logic [15:0] ex_result, mem_result, wb_result;

  logic [15:0] a_corr_rs, a_corr_rt, b_corr_rs, b_corr_rt;
  logic        a_fwd_rs, a_fwd_rt, a_stl, a_freeze, a_busy;
  logic        b_fwd_rs, b_fwd_rt, b_stl, b_freeze, b_busy;
  logic [15:0] a_stall_cnt, a_fwd_cnt;
  logic [3:0]  b_stall_cnt, b_fwd_cnt;

  int checks   = 0;
  int failures = 0;
  int stl_cycles;

  hazard_ctrl_seq #(.DATA_W(16), .RADDR_W(4), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .mem_busy(mem_busy), .flush(flush), .perf_clr(perf_clr),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rs_used(fd_rs_used), .fd_rt_used(fd_rt_used),
    .dx_rd(dx_rd), .xm_rd(xm_rd), .mw_rd(mw_rd), .dx_wr(dx_wr), .xm_wr(xm_wr), .mw_wr(mw_wr),
    .dx_ld(dx_ld), .xm_ld(xm_ld), .ex_result(ex_result), .mem_result(mem_result),
    .wb_result(wb_result), .corr_rs(a_corr_rs), .corr_rt(a_corr_rt), .fwd_rs(a_fwd_rs),
    .fwd_rt(a_fwd_rt), .stl(a_stl), .freeze(a_freeze), .busy(a_busy),
    .stall_cnt(a_stall_cnt), .fwd_cnt(a_fwd_cnt)
  );

  hazard_ctrl_seq #(.DATA_W(16), .RADDR_W(4), .LOAD_LAT(2), .CNT_W(4)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .mem_busy(mem_busy), .flush(flush), .perf_clr(perf_clr),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rs_used(fd_rs_used), .fd_rt_used(fd_rt_used),
    .dx_rd(dx_rd), .xm_rd(xm_rd), .mw_rd(mw_rd), .dx_wr(dx_wr), .xm_wr(xm_wr), .mw_wr(mw_wr),
    .dx_ld(dx_ld), .xm_ld(xm_ld), .ex_result(ex_result), .mem_result(mem_result),
    .wb_result(wb_result), .corr_rs(b_corr_rs), .corr_rt(b_corr_rt), .fwd_rs(b_fwd_rs),
    .fwd_rt(b_fwd_rt), .stl(b_stl), .freeze(b_freeze), .busy(b_busy),
    .stall_cnt(b_stall_cnt), .fwd_cnt(b_fwd_cnt)
  );

  task automatic idle();
    mem_busy = 0; flush = 0; perf_clr = 0;
    fd_rs = 0; fd_rt = 0; fd_rs_used = 0; fd_rt_used = 0;
    dx_rd = 0; xm_rd = 0; mw_rd = 0; dx_wr = 0; xm_wr = 0; mw_wr = 0;
    dx_ld = 0; xm_ld = 0; ex_result = 0; mem_result = 0; wb_result = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    next();
    next();
    rst_n = 1;
  endtask

  // lw r4 in DX, decode reads rt=r4
  task automatic lw_in_dx();
    idle();
    dx_ld = 1; dx_wr = 1; dx_rd = 4; fd_rt = 4; fd_rt_used = 1;
  endtask

  task automatic lw_in_xm();
    idle();
    xm_ld = 1; xm_wr = 1; xm_rd = 4; mem_result = 16'hABCD; fd_rt = 4; fd_rt_used = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    fd_rs = 3; fd_rs_used = 1; dx_wr = 1; dx_rd = 3; ex_result = 16'h1234;
    fd_rt = 5; fd_rt_used = 1; xm_ld = 1; xm_wr = 1; xm_rd = 5; mem_busy = 1;
    #1;
    checks++; if (a_fwd_rs !== 1'b0) begin failures++; $display("FAIL rst_fwd_rs got=%0h exp=0", a_fwd_rs); end
    checks++; if (a_corr_rs !== 16'h0) begin failures++; $display("FAIL rst_corr_rs got=%0h exp=0", a_corr_rs); end
    checks++; if (b_stl !== 1'b0) begin failures++; $display("FAIL rst_stl got=%0h exp=0", b_stl); end
    checks++; if (a_freeze !== 1'b0) begin failures++; $display("FAIL rst_freeze got=%0h exp=0", a_freeze); end
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", b_busy); end
    next();
    next();
    checks++; if (a_stall_cnt !== 16'h0 || b_stall_cnt !== 4'h0) begin failures++; $display("FAIL rst_stall_cnt got=%0h/%0h exp=0", a_stall_cnt, b_stall_cnt); end
    checks++; if (a_fwd_cnt !== 16'h0) begin failures++; $display("FAIL rst_fwd_cnt got=%0h exp=0", a_fwd_cnt); end
    idle();
    rst_n = 1;
  endtask

  task automatic test_ex_fwd();
    do_reset();
    dx_wr = 1; dx_rd = 3; ex_result = 16'h1234; fd_rs = 3; fd_rs_used = 1;
    #1;
    checks++; if (a_fwd_rs !== 1'b1) begin failures++; $display("FAIL ex_fwd_rs got=%0h exp=1", a_fwd_rs); end
    checks++; if (a_corr_rs !== 16'h1234) begin failures++; $display("FAIL ex_corr_rs got=%0h exp=1234", a_corr_rs); end
    checks++; if (a_stl !== 1'b0) begin failures++; $display("FAIL ex_stl got=%0h exp=0", a_stl); end
    checks++; if (a_fwd_rt !== 1'b0 || a_corr_rt !== 16'h0) begin failures++; $display("FAIL ex_no_rt got=%0h/%0h exp=0/0", a_fwd_rt, a_corr_rt); end
    next();
    checks++; if (a_fwd_cnt !== 16'd1) begin failures++; $display("FAIL ex_fwd_cnt got=%0d exp=1", a_fwd_cnt); end
    fd_rt = 3; fd_rt_used = 1;
    #1;
    checks++; if (a_fwd_rt !== 1'b1 || a_corr_rt !== 16'h1234) begin failures++; $display("FAIL ex_both_rt got=%0h/%0h exp=1/1234", a_fwd_rt, a_corr_rt); end
    next();
    checks++; if (a_fwd_cnt !== 16'd2) begin failures++; $display("FAIL ex_both_cnt got=%0d exp=2", a_fwd_cnt); end
    fd_rt_used = 0;
    #1;
    checks++; if (a_fwd_rt !== 1'b0) begin failures++; $display("FAIL ex_unused_rt got=%0h exp=0", a_fwd_rt); end
    idle();
  endtask

  task automatic test_priority();
    do_reset();
    dx_wr = 1; xm_wr = 1; mw_wr = 1; dx_rd = 3; xm_rd = 3; mw_rd = 3;
    ex_result = 16'd5; mem_result = 16'd6; wb_result = 16'd7; fd_rs = 3; fd_rs_used = 1;
    #1;
    checks++; if (a_corr_rs !== 16'd5 || b_corr_rs !== 16'd5) begin failures++; $display("FAIL prio_ex got=%0d/%0d exp=5", a_corr_rs, b_corr_rs); end
    fd_rs = 0;
    #1;
    checks++; if (a_fwd_rs !== 1'b0 || a_corr_rs !== 16'h0) begin failures++; $display("FAIL prio_r0 got=%0h/%0h exp=0/0", a_fwd_rs, a_corr_rs); end
    next();
    fd_rs = 3; dx_rd = 2;
    #1;
    checks++; if (a_corr_rs !== 16'd6) begin failures++; $display("FAIL prio_mem got=%0d exp=6", a_corr_rs); end
    xm_rd = 2;
    #1;
    checks++; if (a_corr_rs !== 16'd7 || a_fwd_rs !== 1'b1) begin failures++; $display("FAIL prio_wb got=%0d/%0h exp=7/1", a_corr_rs, a_fwd_rs); end
    next();
    xm_rd = 3; xm_ld = 1; flush = 1;
    #1;
    checks++; if (a_corr_rs !== 16'd6) begin failures++; $display("FAIL ld_mem_lat1 got=%0d exp=6", a_corr_rs); end
    checks++; if (b_fwd_rs !== 1'b0 || b_corr_rs !== 16'h0) begin failures++; $display("FAIL ld_mem_block_lat2 got=%0h/%0h exp=0/0", b_fwd_rs, b_corr_rs); end
    checks++; if (b_stl !== 1'b0) begin failures++; $display("FAIL flush_run_stl got=%0h exp=0", b_stl); end
    next();
    xm_ld = 0; dx_rd = 3; dx_ld = 1;
    #1;
    checks++; if (a_fwd_rs !== 1'b0) begin failures++; $display("FAIL ld_ex_block got=%0h exp=0", a_fwd_rs); end
    flush = 0;
    #1;
    checks++; if (a_stl !== 1'b1) begin failures++; $display("FAIL ld_ex_stl got=%0h exp=1", a_stl); end
    idle();
  endtask

  task automatic test_load_use_lat1();
    do_reset();
    lw_in_dx();
    #1;
    checks++; if (a_stl !== 1'b1) begin failures++; $display("FAIL lu1_a_stl got=%0h exp=1", a_stl); end
    checks++; if (a_fwd_rt !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL lu1_a_fwd_busy got=%0h/%0h exp=0/0", a_fwd_rt, a_busy); end
    next();
    lw_in_xm();
    #1;
    checks++; if (a_stl !== 1'b0) begin failures++; $display("FAIL lu1_b_stl got=%0h exp=0", a_stl); end
    checks++; if (a_fwd_rt !== 1'b1 || a_corr_rt !== 16'hABCD) begin failures++; $display("FAIL lu1_b_fwd got=%0h/%0h exp=1/abcd", a_fwd_rt, a_corr_rt); end
    checks++; if (a_stall_cnt !== 16'd1) begin failures++; $display("FAIL lu1_stall_cnt got=%0d exp=1", a_stall_cnt); end
    next();
    checks++; if (a_fwd_cnt !== 16'd1 || a_stall_cnt !== 16'd1) begin failures++; $display("FAIL lu1_cnts got=%0d/%0d exp=1/1", a_fwd_cnt, a_stall_cnt); end
    idle();
  endtask

  task automatic test_load_use_lat2();
    do_reset();
    lw_in_dx();
    #1;
    checks++; if (b_stl !== 1'b1 || b_busy !== 1'b0) begin failures++; $display("FAIL lu2_a got=%0h/%0h exp=1/0", b_stl, b_busy); end
    next();
    lw_in_xm();
    #1;
    checks++; if (b_stl !== 1'b1 || b_busy !== 1'b1) begin failures++; $display("FAIL lu2_b got=%0h/%0h exp=1/1", b_stl, b_busy); end
    checks++; if (b_fwd_rt !== 1'b0 || b_stall_cnt !== 4'd1) begin failures++; $display("FAIL lu2_b_fwd_cnt got=%0h/%0d exp=0/1", b_fwd_rt, b_stall_cnt); end
    next();
    idle();
    mw_wr = 1; mw_rd = 4; wb_result = 16'hBEEF; fd_rt = 4; fd_rt_used = 1;
    #1;
    checks++; if (b_stl !== 1'b0 || b_busy !== 1'b0) begin failures++; $display("FAIL lu2_c got=%0h/%0h exp=0/0", b_stl, b_busy); end
    checks++; if (b_fwd_rt !== 1'b1 || b_corr_rt !== 16'hBEEF) begin failures++; $display("FAIL lu2_c_fwd got=%0h/%0h exp=1/beef", b_fwd_rt, b_corr_rt); end
    checks++; if (b_stall_cnt !== 4'd2) begin failures++; $display("FAIL lu2_stall_cnt got=%0d exp=2", b_stall_cnt); end
    next();
    checks++; if (b_fwd_cnt !== 4'd1) begin failures++; $display("FAIL lu2_fwd_cnt got=%0d exp=1", b_fwd_cnt); end
    idle();
  endtask

  task automatic test_freeze();
    do_reset();
    stl_cycles = 0;
    lw_in_dx();
    #1;
    if (b_stl === 1'b1) stl_cycles++;
    next();
    lw_in_xm();
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (b_stl === 1'b1) stl_cycles++;
      checks++; if (b_freeze !== 1'b1 || b_stl !== 1'b1 || b_busy !== 1'b1) begin failures++; $display("FAIL frz_hold%0d got=%0h%0h%0h exp=111", i, b_freeze, b_stl, b_busy); end
      next();
    end
    checks++; if (b_stall_cnt !== 4'd1) begin failures++; $display("FAIL frz_cnt_held got=%0d exp=1", b_stall_cnt); end
    mem_busy = 0;
    #1;
    if (b_stl === 1'b1) stl_cycles++;
    checks++; if (b_freeze !== 1'b0 || b_stl !== 1'b1) begin failures++; $display("FAIL frz_release got=%0h/%0h exp=0/1", b_freeze, b_stl); end
    next();
    idle();
    mw_wr = 1; mw_rd = 4; fd_rt = 4; fd_rt_used = 1;
    #1;
    checks++; if (b_stl !== 1'b0 || b_busy !== 1'b0) begin failures++; $display("FAIL frz_done got=%0h/%0h exp=0/0", b_stl, b_busy); end
    checks++; if (stl_cycles != 5) begin failures++; $display("FAIL frz_stl_cycles got=%0d exp=5", stl_cycles); end
    checks++; if (b_stall_cnt !== 4'd2) begin failures++; $display("FAIL frz_stall_cnt got=%0d exp=2", b_stall_cnt); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    lw_in_dx();
    next();
    lw_in_xm();
    flush = 1;
    #1;
    checks++; if (b_stl !== 1'b1 || b_busy !== 1'b1) begin failures++; $display("FAIL fl_stall got=%0h/%0h exp=1/1", b_stl, b_busy); end
    next();
    idle();
    #1;
    checks++; if (b_stl !== 1'b0 || b_busy !== 1'b0) begin failures++; $display("FAIL fl_run got=%0h/%0h exp=0/0", b_stl, b_busy); end
    lw_in_dx();
    next();
    lw_in_xm();
    mem_busy = 1; flush = 1;
    next();
    mem_busy = 0; flush = 0;
    #1;
    checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL fl_ignored_frozen got=%0h exp=1", b_busy); end
    next();
    lw_in_dx();
    next();
    #1;
    rst_n = 0;
    #1;
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL async_rst_busy got=%0h exp=0", b_busy); end
    rst_n = 1;
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    lw_in_dx();
    for (int i = 0; i < 20; i++) next();
    checks++; if (b_stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_stall_lat2 got=%0h exp=f", b_stall_cnt); end
    checks++; if (a_stall_cnt !== 16'd20) begin failures++; $display("FAIL b2b_stall_lat1 got=%0d exp=20", a_stall_cnt); end
    next();
    checks++; if (b_stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_stall_hold got=%0h exp=f", b_stall_cnt); end
    perf_clr = 1;
    next();
    checks++; if (b_stall_cnt !== 4'h0 || a_stall_cnt !== 16'h0) begin failures++; $display("FAIL clr_stall got=%0h/%0h exp=0/0", b_stall_cnt, a_stall_cnt); end
    perf_clr = 0;
    next();
    checks++; if (b_stall_cnt !== 4'd1) begin failures++; $display("FAIL clr_then_inc got=%0d exp=1", b_stall_cnt); end
    idle();
    dx_wr = 1; dx_rd = 3; ex_result = 16'h0042; fd_rs = 3; fd_rs_used = 1;
    for (int i = 0; i < 18; i++) next();
    checks++; if (b_fwd_cnt !== 4'hF) begin failures++; $display("FAIL sat_fwd got=%0h exp=f", b_fwd_cnt); end
    perf_clr = 1;
    next();
    checks++; if (b_fwd_cnt !== 4'h0) begin failures++; $display("FAIL clr_fwd got=%0h exp=0", b_fwd_cnt); end
    idle();
  endtask

  initial begin
    test_reset();
    test_ex_fwd();
    test_priority();
    test_load_use_lat1();
    test_load_use_lat2();
    test_freeze();
    test_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
